// File: rtl/mux_n_1_wb_reg_pkg.sv
// Shared constants for the N:1 registered multiplexer.
// Holds the mode encodings and a constant-foldable clog2 used to size
// channel indices. Build option MUX_RR_EN enables round-robin mode in
// the top level.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Smallest r with (1 << r) >= n; usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_1_wb_reg_if.sv
// Bus bundle between the channel sources / downstream sink (master side)
// and the multiplexer (slave side).
//
// Handshake: a transfer on input channel i happens on a rising edge where
// in_valid[i] && in_ready[i]; a transfer on the output happens on a rising
// edge where out_valid && out_ready. in_ready is a combinational response to
// the current cycle's inputs and is one-hot or zero. out_data/out_chan are
// stable while out_valid is high and out_ready is low.
interface mux_n_1_wb_reg_if
  import mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 16
);

  localparam int SEL_W = clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/mux_n_1_wb_reg_rr_pick.sv
// Combinational round-robin picker: finds the first requesting channel
// strictly after ptr, wrapping from CHANNELS-1 back to 0. ptr itself is
// examined last, so a lone requester is still found.
module rr_pick
  import mux_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                found
);

  localparam int NPAD = 1 << SEL_W;

  logic [NPAD-1:0]  req_pad;
  logic [SEL_W-1:0] idx;

  // Scan ptr+1 .. ptr+CHANNELS (mod CHANNELS); first hit wins.
  always_comb begin
    req_pad = '0;
    req_pad[CHANNELS-1:0] = req;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = SEL_W'((int'(ptr) + i) % CHANNELS);
      if (!found && req_pad[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_wb_reg.sv
// N:1 multiplexer with a registered, back-pressurable output stage.
// Direct mode forwards channel 'sel'; with build macro MUX_RR_EN defined a
// round-robin mode (mode=1) is also available, arbitrating from the channel
// after the last one transferred. Without MUX_RR_EN the mode input is
// ignored and only direct mode exists.
module mux_n_1_wb_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_n_1_wb_reg_if.slave    bus
);

  localparam int SEL_W = clog2(CHANNELS);
  // Channel space rounded up to a power of two so any sel value indexes
  // safely; padded channels never request, so an out-of-range sel never wins.
  localparam int NPAD  = 1 << SEL_W;

  logic                  load;
  logic                  found;
  logic                  direct_found;
  logic [SEL_W-1:0]      gidx;
  logic [NPAD-1:0]       valid_pad;
  logic [NPAD-1:0]       ready_pad;
  logic [NPAD*WIDTH-1:0] data_pad;

  logic [WIDTH-1:0]      out_data_q;
  logic [SEL_W-1:0]      out_chan_q;
  logic                  out_valid_q;

  // Zero-extend channel vectors into the padded index space.
  always_comb begin
    valid_pad = '0;
    valid_pad[CHANNELS-1:0] = bus.in_valid;
    data_pad = '0;
    data_pad[CHANNELS*WIDTH-1:0] = bus.in_data;
  end

  assign load         = !out_valid_q || bus.out_ready;
  assign direct_found = valid_pad[bus.sel];

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .grant (rr_idx),
    .found (rr_found)
  );

  // Choose the grant source for this cycle from the current mode.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    if (bus.mode == MODE_RR) begin
      found = rr_found;
      gidx  = rr_idx;
    end else if (bus.mode == MODE_DIRECT) begin
      found = direct_found;
      gidx  = bus.sel;
    end
  end

  // Remember the last transferred channel, whatever mode produced it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= SEL_W'(CHANNELS - 1);
    end else if (load && found) begin
      ptr_q <= gidx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign found       = direct_found;
  assign gidx        = bus.sel;
`endif

  // Accept strobe goes only to the granted channel, only when the output
  // register can take a word, and never while reset is asserted.
  always_comb begin
    ready_pad = '0;
    if (rst_n && load && found) ready_pad[gidx] = 1'b1;
  end
  assign bus.in_ready = ready_pad[CHANNELS-1:0];

  // Output stage: load on grant, drain to empty when nothing is granted,
  // hold while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else if (load) begin
      if (found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= data_pad[gidx*WIDTH +: WIDTH];
        out_chan_q  <= gidx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule
